// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus_uart peripheral.
//   - Register offsets within the 4-byte window.
//   - STAT bit positions, for both the read view and the write-command view.
//   - TX/RX engine state encoding.
//   - Divider clamp helper.
package bus_uart_pkg;

    localparam logic [1:0] OFS_DATA = 2'd0;
    localparam logic [1:0] OFS_STAT = 2'd1;
    localparam logic [1:0] OFS_DIVL = 2'd2;
    localparam logic [1:0] OFS_DIVH = 2'd3;

    // STAT read bit positions
    localparam int STAT_RXV     = 0;
    localparam int STAT_TXFULL  = 1;
    localparam int STAT_TXEMPTY = 2;
    localparam int STAT_OVR     = 3;
    localparam int STAT_FERR    = 4;
    localparam int STAT_IERX    = 6;
    localparam int STAT_IETX    = 7;

    // STAT write command bits. The clear bits do not line up with the
    // read positions of the flags they clear.
    localparam int WSTAT_CLR_RXV  = 0;
    localparam int WSTAT_CLR_OVR  = 2;
    localparam int WSTAT_CLR_FERR = 3;
    localparam int WSTAT_IERX     = 6;
    localparam int WSTAT_IETX     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks-per-bit below 2 cannot yield a mid-bit sample point.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/bus_uart_if.sv
// CPU data-bus view of the bus_uart peripheral.
//   read    : 1 = read cycle, 0 = write cycle (CPU -> UART)
//   address : 16-bit bus address            (CPU -> UART)
//   wdata   : store data                    (CPU -> UART)
//   rdata   : read data for the din mux     (UART -> CPU)
//   cs      : address decode hit            (UART -> CPU)
interface bus_uart_if;
    logic        read;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        cs;

    modport master (output read, output address, output wdata,
                    input  rdata, input  cs);
    modport slave  (input  read, input  address, input  wdata,
                    output rdata, output cs);
endinterface

// File: rtl/bus_uart_txfifo.sv
// Synchronous FIFO used as the UART transmit queue.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push_i   : write din_i when not full; ignored when full
//   pop_i    : advance read pointer when not empty
//   dout_o   : current head entry
//   full_o, empty_o, count_o : occupancy status
module uart_txfifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [W-1:0]          din_i,
    input  logic                  pop_i,
    output logic [W-1:0]          dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == DEPTH[DEPTH_LOG2:0]);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at their DEPTH_LOG2 width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART on the CPU data bus.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of bus_uart_if (read/address/wdata in, rdata/cs out)
//   txd      : serial transmit, idle high
//   rxd      : serial receive, asynchronous to clk
//   irq      : registered interrupt request
// Map at BASE+0..3: DATA (W: TX push, R: rx byte), STAT, DIVL, DIVH.
// Reads are free of side effects; only stores change state.
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter logic [15:0] BASE         = 16'hFF00,
    parameter logic [15:0] DIV_RESET    = 16'd434,
    parameter int          TXDEPTH_LOG2 = 2
) (
    input  logic      clk,
    input  logic      rst,
    bus_uart_if.slave bus,
    output logic      txd,
    input  logic      rxd,
    output logic      irq
);
    logic [1:0] ofs;
    logic       wr_stb, wr_data, wr_stat;

    assign bus.cs  = (bus.address[15:2] == BASE[15:2]);
    assign ofs     = bus.address[1:0];
    assign wr_stb  = bus.cs && !bus.read;
    assign wr_data = wr_stb && (ofs == OFS_DATA);
    assign wr_stat = wr_stb && (ofs == OFS_STAT);

    logic [15:0] div_q, div_d;
    logic        ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;
    logic        rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        irq_q;

    logic                  fifo_pop, fifo_full, fifo_empty;
    logic [7:0]            fifo_dout;
    logic [TXDEPTH_LOG2:0] fifo_count;

    uart_txfifo #(.DEPTH_LOG2(TXDEPTH_LOG2), .W(8)) u_txfifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_data),
        .din_i   (bus.wdata),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------- TX engine ----------------
    uart_state_e tx_state_q;
    logic [15:0] tx_div_q, tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_sh_q;
    logic        txd_q, tx_bit_end, tx_empty;

    assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
    assign fifo_pop   = (tx_state_q == IDLE) && !fifo_empty;
    assign tx_empty   = (fifo_count == '0) && (tx_state_q == IDLE);
    assign txd        = txd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            txd_q      <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    // Divider is captured here so mid-frame DIV writes wait for the next frame.
                    if (fifo_pop) begin
                        tx_state_q <= START;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_sh_q    <= fifo_dout;
                        tx_div_q   <= eff_div(div_q);
                    end
                end
                START: begin
                    if (tx_bit_end) begin
                        tx_state_q <= DATA;
                        txd_q      <= tx_sh_q[0];
                        tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            txd_q   <= tx_sh_q[0];
                            tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (tx_bit_end) begin
                        tx_state_q <= IDLE;
                        tx_cnt_q   <= '0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    // ---------------- RX engine ----------------
    uart_state_e rx_state_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_div_q, rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_bit_end, rx_half_end, rx_stop_smp, rx_done_ok, rx_done_bad;

    assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
    assign rx_stop_smp = (rx_state_q == STOP) && rx_bit_end;
    assign rx_done_ok  = rx_stop_smp && rx_s2_q;
    assign rx_done_bad = rx_stop_smp && !rx_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= START;
                        rx_cnt_q   <= '0;
                        rx_div_q   <= eff_div(div_q);
                    end
                end
                START: begin
                    // Half-bit re-check rejects short glitches and centres later samples.
                    if (rx_half_end) begin
                        rx_state_q <= rx_s2_q ? IDLE : DATA;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (rx_bit_end) begin
                        rx_state_q <= IDLE;
                        rx_cnt_q   <= '0;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= IDLE;
            endcase
        end
    end

    // ---------------- Register file ----------------
    always_comb begin
        div_d      = div_q;
        ie_rx_d    = ie_rx_q;
        ie_tx_d    = ie_tx_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;
        rx_byte_d  = rx_byte_q;
        if (wr_stb && ofs == OFS_DIVL) div_d[7:0]  = bus.wdata;
        if (wr_stb && ofs == OFS_DIVH) div_d[15:8] = bus.wdata;
        if (wr_stat) begin
            ie_rx_d = bus.wdata[WSTAT_IERX];
            ie_tx_d = bus.wdata[WSTAT_IETX];
            if (bus.wdata[WSTAT_CLR_RXV])  rx_valid_d = 1'b0;
            if (bus.wdata[WSTAT_CLR_OVR])  ovr_d      = 1'b0;
            if (bus.wdata[WSTAT_CLR_FERR]) ferr_d     = 1'b0;
        end
        // Evaluated after the clear so a same-cycle clear lets the new byte in.
        if (rx_done_ok) begin
            if (!rx_valid_d) begin
                rx_byte_d  = rx_sh_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (rx_done_bad) ferr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_RESET;
            ie_rx_q    <= 1'b0;
            ie_tx_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            ie_rx_q    <= ie_rx_d;
            ie_tx_q    <= ie_tx_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= (rx_valid_q && ie_rx_q) || (tx_empty && ie_tx_q);
        end
        rx_byte_q <= rx_byte_d;
    end

    assign irq = irq_q;

    // ---------------- Read mux ----------------
    logic [7:0] stat;

    always_comb begin
        stat               = '0;
        stat[STAT_RXV]     = rx_valid_q;
        stat[STAT_TXFULL]  = fifo_full;
        stat[STAT_TXEMPTY] = tx_empty;
        stat[STAT_OVR]     = ovr_q;
        stat[STAT_FERR]    = ferr_q;
        stat[STAT_IERX]    = ie_rx_q;
        stat[STAT_IETX]    = ie_tx_q;
    end

    always_comb begin
        case (ofs)
            OFS_DATA: bus.rdata = rx_byte_q;
            OFS_STAT: bus.rdata = stat;
            OFS_DIVL: bus.rdata = div_q[7:0];
            default:  bus.rdata = div_q[15:8];
        endcase
    end

endmodule

// File: tb/tb_bus_uart.sv
// Directed bench for bus_uart: TX frames are decoded by a line monitor and
// compared against a queue of expected bytes; RX bytes are queued when driven
// and compared when read back through DATA.
module tb_bus_uart;
    import bus_uart_pkg::*;

    localparam logic [15:0] BASE = 16'hFF00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd, irq;

    bus_uart_if bif();

    bus_uart #(.BASE(BASE), .DIV_RESET(16'd434), .TXDEPTH_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif),
        .txd (txd),
        .rxd (rxd),
        .irq (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cur_div  = 434;
    bit mon_en   = 1'b1;
    int tx_frames = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] ofs, input logic [7:0] d);
        @(negedge clk);
        bif.read = 1'b0; bif.address = {BASE[15:2], ofs}; bif.wdata = d;
        @(negedge clk);
        bif.read = 1'b1; bif.address = 16'h0000;
    endtask

    task automatic bus_read(input logic [1:0] ofs, output logic [7:0] d);
        @(negedge clk);
        bif.read = 1'b1; bif.address = {BASE[15:2], ofs};
        #1 d = bif.rdata;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] ofs, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(ofs, v);
        check(tag, v, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk); rxd = 1'b0;
        repeat (cur_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (cur_div) @(negedge clk);
        end
        rxd = stop;
        if (!stop) begin
            repeat (cur_div) @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic wait_txd_low(input string tag);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check(tag, txd, 1'b0);
    endtask

    task automatic wait_tx_idle(input string tag, input int bound);
        logic [7:0] s;
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        while (!ok && n < bound) begin
            bus_read(OFS_STAT, s);
            ok = s[STAT_TXEMPTY] && (tx_exp.size() == 0);
            n++;
        end
        check(tag, ok, 1'b1);
    endtask

    // TX line monitor: mid-bit sampling of each frame.
    initial begin : tx_mon
        logic       prev, st, sp;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !txd && mon_en) begin
                tx_starts.push_back(cyc);
                repeat (cur_div / 2) @(negedge clk);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (cur_div) @(negedge clk);
                    b[i] = txd;
                end
                repeat (cur_div) @(negedge clk);
                sp = txd;
                if (mon_en) begin
                    tx_frames++;
                    check("tx_start_bit", st, 1'b0);
                    check("tx_stop_bit", sp, 1'b1);
                    checks++;
                    assert (tx_exp.size() != 0) else begin
                        failures++;
                        $error("FAIL tx_unexpected_frame observed=0x%0h expected=none", b);
                    end
                    if (tx_exp.size() != 0) check("tx_byte", b, tx_exp.pop_front());
                end
            end
            prev = txd;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [9:0] fr;
        logic [7:0] s, rx_hold;
        int n, mcount, accepted, frames0;
        bit mbusy, mpop, mpush, gap_ok;

        bif.read = 1'b1; bif.address = 16'h0000; bif.wdata = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        check_reg("rst_stat", OFS_STAT, 8'h04);
        check_reg("rst_divl", OFS_DIVL, 8'hB2);
        check_reg("rst_divh", OFS_DIVH, 8'h01);
        #1 check("cs_hit", bif.cs, 1'b1);
        bif.address = 16'h1234;
        #1 check("cs_miss", bif.cs, 1'b0);

        // Single frame with exact bit timing
        bus_write(OFS_DIVL, 8'd4);
        bus_write(OFS_DIVH, 8'd0);
        cur_div = 4;
        check_reg("divl_rw", OFS_DIVL, 8'h04);
        tx_exp.push_back(8'hA5);
        bus_write(OFS_DATA, 8'hA5);
        wait_txd_low("a5_start_seen");
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            check($sformatf("a5_wave_clk%0d", k), txd, fr[k / 4]);
            @(negedge clk);
        end
        wait_tx_idle("a5_done", 40);
        check_reg("a5_stat_after", OFS_STAT, 8'h04);

        // Back-to-back burst of five stores
        tx_starts.delete();
        frames0 = tx_frames;
        mcount = 0; mbusy = 1'b0; accepted = 0;
        for (int i = 0; i < 5; i++) begin
            mpop  = !mbusy && (mcount > 0);
            mpush = (mcount < 4);
            if (mpush) begin tx_exp.push_back(8'(i + 1)); accepted++; end
            mcount = mcount + int'(mpush) - int'(mpop);
            if (mpop) mbusy = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bif.read = 1'b0; bif.address = {BASE[15:2], OFS_DATA}; bif.wdata = 8'(i + 1);
            @(negedge clk);
        end
        bif.read = 1'b1; bif.address = 16'h0000;
        bus_read(OFS_STAT, s);
        check("burst_tx_full", s[STAT_TXFULL], (mcount == 4));
        wait_tx_idle("burst_done", 400);
        check("burst_frames", tx_frames - frames0, accepted);
        check("burst_starts", tx_starts.size(), accepted);
        for (int j = 1; j < tx_starts.size(); j++) begin
            gap_ok = (tx_starts[j] - tx_starts[j-1] >= 10 * cur_div) &&
                     (tx_starts[j] - tx_starts[j-1] <= 10 * cur_div + 1);
            check($sformatf("burst_gap%0d", j), gap_ok, 1'b1);
        end

        // RX reception, overrun, clear
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (12) @(negedge clk);
        check_reg("rx1_stat", OFS_STAT, 8'h05);
        rx_hold = rx_exp.pop_front();
        check_reg("rx1_data", OFS_DATA, rx_hold);
        send_rx(8'h77, 1'b1);
        repeat (12) @(negedge clk);
        check_reg("ovr_stat", OFS_STAT, 8'h0D);
        check_reg("ovr_data_kept", OFS_DATA, rx_hold);
        bus_write(OFS_STAT, 8'h05);
        check_reg("clr_stat", OFS_STAT, 8'h04);

        // Framing error, then glitch rejection
        send_rx(8'hC3, 1'b0);
        repeat (12) @(negedge clk);
        check_reg("ferr_stat", OFS_STAT, 8'h14);
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (60) @(negedge clk);
        check_reg("glitch_stat", OFS_STAT, 8'h14);
        bus_write(OFS_STAT, 8'h08);
        check_reg("ferr_clr_stat", OFS_STAT, 8'h04);

        // Reset during TX data bit 3
        mon_en = 1'b0;
        bus_write(OFS_DATA, 8'h96);
        wait_txd_low("rst_frame_start");
        bus_write(OFS_DATA, 8'h69);
        repeat (16) @(negedge clk);
        check("pre_rst_bit3", txd, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("txd_after_rst", txd, 1'b1);
        rst = 1'b0;
        check_reg("rst2_stat", OFS_STAT, 8'h04);
        check_reg("rst2_divl", OFS_DIVL, 8'hB2);
        repeat (60) @(negedge clk);
        check("rst2_txd_idle", txd, 1'b1);
        check_reg("rst2_stat_later", OFS_STAT, 8'h04);
        tx_exp.delete();
        mon_en = 1'b1;

        // Interrupt on RX
        bus_write(OFS_DIVL, 8'd4);
        bus_write(OFS_DIVH, 8'd0);
        cur_div = 4;
        bus_write(OFS_STAT, 8'h40);
        check_reg("ie_stat", OFS_STAT, 8'h44);
        check("irq_idle", irq, 1'b0);
        rx_exp.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        bif.address = {BASE[15:2], OFS_STAT};
        n = 0;
        #1;
        while (bif.rdata[STAT_RXV] !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("irq_rxv_seen", bif.rdata[STAT_RXV], 1'b1);
        check("irq_not_yet", irq, 1'b0);
        @(negedge clk); #1;
        check("irq_asserted", irq, 1'b1);
        check_reg("irq_rx_data", OFS_DATA, rx_exp.pop_front());
        bus_write(OFS_STAT, 8'h41);
        repeat (2) @(negedge clk);
        check("irq_cleared", irq, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_uart.md
Name: bus_uart

Overview:
- Memory-mapped 8N1 UART peripheral on the microcpu data bus.
- Sits downstream of the CPU: decodes address, accepts byte writes and returns read data for the top-level din mux.
- Contains a 4-entry TX FIFO, a single-byte RX holding register and a programmable baud divider.
- Gives firmware polled serial I/O without read side effects, because instruction fetch and load cycles are indistinguishable on the bus.

Parameters:
- BASE, 16'hFF00, base address; block decodes BASE..BASE+3 (BASE[1:0] must be 0).
- DIV_RESET, 16'd434, reset value of the clocks-per-bit divider (50 MHz / 115200).
- TXDEPTH_LOG2, 2, TX FIFO depth = 4 entries.

Ports:
- clk  in  1  system clock; same clock as CPU. Block logic uses posedge; CPU uses negedge.
- rst  in  1  synchronous, active-high reset.
- read  in  1  CPU read flag; 0 = write cycle (held low exactly one clk period).
- address  in  16  CPU bus address.
- wdata  in  8  CPU write data (CPU dout).
- rdata  out  8  read data to CPU din mux; combinational from address and registers.
- cs  out  1  combinational; high when address[15:2] == BASE[15:2]. Top uses it to select rdata.
- txd  out  1  serial transmit, idle high.
- rxd  in  1  serial receive, asynchronous.
- irq  out  1  registered; rx_valid OR (tx_empty AND ie_tx), gated by ie_rx for the rx_valid term.

Behaviour:
- Register map (offset address[1:0]):
  - 0 DATA: W pushes TX FIFO; R returns rx_byte.
  - 1 STAT: R = {ie_tx, ie_rx, 1'b0, ferr, ovr, tx_empty, tx_full, rx_valid}. W bit0 = 1 clears rx_valid; bit2 = 1 clears ovr; bit3 = 1 clears ferr; bits6,7 write ie_rx, ie_tx.
  - 2 DIVL: divider[7:0], R/W.
  - 3 DIVH: divider[15:8], R/W.
- Write strobe: cs AND NOT read, sampled at posedge. One strobe per CPU store. Reads have no side effects.
- Reset values:
  - txd = 1, irq = 0, FIFO empty, rx_valid = 0, ovr = 0, ferr = 0, ie_rx = 0, ie_tx = 0, divider = DIV_RESET.
  - rdata follows the map (STAT reads 8'h04 after reset).
- Divider: a value below 2 is treated as 2. Latched into the TX and RX engines at their frame starts; writing mid-frame affects only later frames.
- TX FIFO:
  - Push when not full. Push while full: byte dropped, no flag.
  - Push and pop in the same cycle both take effect.
  - Pointers wrap modulo depth; count register is TXDEPTH_LOG2+1 bits.
  - tx_full = (count == depth).
  - tx_empty = (count == 0) AND TX engine IDLE.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each bit lasts exactly divider clks.
  - IDLE pops the FIFO head when non-empty; START begins the next clk.
  - Back-to-back frames: no idle gap beyond 1 clk.
- RX:
  - rxd passes through a 2-flop synchronizer, preset to 1 on reset.
  - FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: on a falling edge, wait divider/2 clks; if the line is still 0, go to DATA, otherwise return to IDLE (glitch reject).
  - DATA: sample every divider clks, 8 bits, LSB first.
  - STOP: sample; 0 sets ferr and the byte is discarded.
  - Valid stop with rx_valid = 0: rx_byte loads, rx_valid = 1.
  - Valid stop with rx_valid = 1: old byte kept, ovr = 1.
  - A same-cycle clear of rx_valid and new-byte arrival: the arrival wins (rx_valid stays 1, new byte loaded, no ovr).
- irq: registered one clk after its cause.
- Reset mid-frame: both FSMs return to IDLE immediately; a partial TX frame is truncated with txd forced high.
- Width rules: divider counters are 16-bit; bit index is 3-bit, wrapping after 7 into STOP.

Decomposition:
- Shared package bus_uart_pkg:
  - Register offsets: OFS_DATA = 0, OFS_STAT = 1, OFS_DIVL = 2, OFS_DIVH = 3.
  - STAT bit-position constants.
  - TX/RX state encodings as localparams: IDLE, START, DATA, STOP.
- One natural sub-module: uart_txfifo (sync FIFO with push, pop, full, empty, count; depth parameter).
- TX and RX engines stay inline in bus_uart.

Test Plan:
- Reset, then read offsets 0..3 -> STAT = 8'h04, DIVL = 8'hB2, DIVH = 8'h01 (DIV_RESET = 434); txd = 1; irq = 0.
- Write DIVL = 4, DIVH = 0, then store 8'hA5 to DATA -> txd low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks; tx_empty returns to 1.
- Five stores 8'h01..8'h05 back-to-back -> fifth dropped when full (tx_full = 1 observed after the fourth store only if the engine has not popped); exactly four or five frames as computed by the bench model; frames contiguous with ≤1-clk gap.
- Drive rxd frame 8'h3C at divider 4 -> rx_valid = 1, DATA reads 8'h3C. Second frame 8'h77 before clearing -> ovr = 1, DATA still 8'h3C. Write STAT 8'h05 -> rx_valid = 0, ovr = 0.
- rxd frame with stop bit 0 -> ferr = 1, rx_valid unchanged. A 1-clk low glitch on rxd -> no reception.
- Assert rst while TX is in DATA bit 3 -> txd = 1 the next clk, FIFO empty, STAT = 8'h04. Set ie_rx and receive a byte -> irq = 1 one clk after rx_valid.
